// File: rtl/systolic_is_ctrl.sv
// Tile-job sequencer for the input-stationary systolic array: clear, activation preload,
// weight streaming, pipeline flush and result drain, with feeder/sink handshakes.
module systolic_is_ctrl #(
    parameter  int ROWS    = 4,
    parameter  int COLS    = 4,
    parameter  int K_W     = 16,
    parameter  int WIDTH_T = 2,
    localparam int CNT_W   = $clog2((1 << K_W) + ROWS + COLS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [K_W-1:0]     cfg_k,
    input  logic [WIDTH_T-1:0] cfg_thres,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               out_ready,
    output logic               out_valid,
    output logic               pipeline_en,
    output logic               reg_clear,
    output logic               cell_sc_en,
    output logic               cscan_en,
    output logic               c_switch,
    output logic [WIDTH_T-1:0] Thres,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, PRELOAD, COMPUTE, FLUSH, DRAIN, DONE, ABORT
    } state_t;

    localparam int FLUSH_LEN = ROWS + COLS - 2;
    localparam logic [CNT_W-1:0] ROWS_LAST  = CNT_W'(ROWS - 1);
    localparam logic [CNT_W-1:0] COLS_LAST  = CNT_W'(COLS - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_LEN > 0) ? FLUSH_LEN - 1 : 0);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [K_W-1:0]   k_reg;
    logic [CNT_W-1:0] k_last;
    logic             accept;

    assign accept = (state == IDLE) && start && (cfg_k != '0);
    assign k_last = CNT_W'(k_reg) - CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            k_reg <= '0;
            Thres <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            err   <= (state == IDLE) && start && (cfg_k == '0);
            if (accept) begin
                k_reg <= cfg_k;
                Thres <= cfg_thres;
            end
        end
    end

    // Beat counter doubles as phase counter; it is cleared on every phase change.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (accept) state_next = CLEAR;
            end
            CLEAR: begin
                state_next = PRELOAD;
                cnt_next   = '0;
            end
            PRELOAD: begin
                if (in_valid) begin
                    if (cnt == ROWS_LAST) begin
                        state_next = COMPUTE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            COMPUTE: begin
                if (in_valid) begin
                    if (cnt == k_last) begin
                        state_next = (FLUSH_LEN == 0) ? DRAIN : FLUSH;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            FLUSH: begin
                if (cnt == FLUSH_LAST) begin
                    state_next = DRAIN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt == COLS_LAST) begin
                        state_next = DONE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            ABORT: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
        // Cancel overrides every other transition; the ABORT cycle issues the array clear.
        if (abort && (state != IDLE) && (state != ABORT)) begin
            state_next = ABORT;
            cnt_next   = '0;
        end
    end

    assign busy        = (state != IDLE);
    assign reg_clear   = (state == CLEAR) || (state == ABORT);
    assign cscan_en    = (state == PRELOAD);
    assign in_ready    = (state == PRELOAD) || (state == COMPUTE);
    assign cell_sc_en  = (state == PRELOAD) && (cnt == '0) && in_valid;
    assign c_switch    = (state == DRAIN);
    assign out_valid   = (state == DRAIN);
    assign done        = (state == DONE) && !abort;
    assign pipeline_en = ((state == COMPUTE) && in_valid) || (state == FLUSH) ||
                         ((state == DRAIN) && out_ready);

endmodule

// File: tb/tb_systolic_is_ctrl.sv
// Scoreboard bench for systolic_is_ctrl: jobs push expected per-job strobe counts,
// a monitor accumulates strobes and compares on done / err / abort return to idle.
module tb_systolic_is_ctrl;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int K_W  = 16;
    localparam int WT   = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [K_W-1:0] cfg_k = '0;
    logic [WT-1:0] cfg_thres = '0;
    logic          in_valid = 1'b1;
    logic          in_ready;
    logic          out_ready = 1'b1;
    logic          out_valid;
    logic          pipeline_en;
    logic          reg_clear;
    logic          cell_sc_en;
    logic          cscan_en;
    logic          c_switch;
    logic [WT-1:0] Thres;
    logic          busy;
    logic          done;
    logic          err;

    systolic_is_ctrl #(.ROWS(ROWS), .COLS(COLS), .K_W(K_W), .WIDTH_T(WT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_k(cfg_k), .cfg_thres(cfg_thres),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .out_valid(out_valid),
        .pipeline_en(pipeline_en), .reg_clear(reg_clear), .cell_sc_en(cell_sc_en),
        .cscan_en(cscan_en), .c_switch(c_switch), .Thres(Thres),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // kind: 0 = completed job, 1 = aborted job, 2 = rejected start
    typedef struct {
        int kind; int clr; int scan; int sc; int pe; int ped; int csw; int lat;
        logic [WT-1:0] thres;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check_output(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic push_exp(input int kind, input int clr, input int scan, input int sc,
                            input int pe, input int ped, input int csw, input int lat,
                            input logic [WT-1:0] th);
        exp_t e;
        e.kind = kind; e.clr = clr; e.scan = scan; e.sc = sc; e.pe = pe;
        e.ped = ped; e.csw = csw; e.lat = lat; e.thres = th;
        sb.push_back(e);
    endtask

    // Input driver: plain mode keeps both valid and ready high; stall mode toggles
    // in_valid 1,0,1,0.. in COMPUTE and holds out_ready low on drain cycles 1..3.
    bit stall_mode = 0;
    bit tgl = 1;
    int didx = 0;
    always @(posedge clk) begin
        #1;
        if (stall_mode && in_ready && !cscan_en) begin
            in_valid = tgl;
            tgl = !tgl;
        end else begin
            in_valid = 1'b1;
            tgl = 1;
        end
        if (stall_mode && c_switch) begin
            out_ready = !(didx >= 1 && didx <= 3);
            didx++;
        end else begin
            out_ready = 1'b1;
            didx = 0;
        end
    end

    // Monitor
    int a_clr = 0, a_scan = 0, a_sc = 0, a_pe = 0, a_ped = 0, a_csw = 0, a_lat = 0;
    bit prev_busy = 0, got_done = 0;

    task automatic clear_acc();
        a_clr = 0; a_scan = 0; a_sc = 0; a_pe = 0; a_ped = 0; a_csw = 0; a_lat = 0;
    endtask

    task automatic pop_check(input int kind);
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL unexpected_event: got kind %0d, expected none", kind);
        end else begin
            e = sb.pop_front();
            check_output("event_kind", kind, e.kind);
            check_output("thres", int'(Thres), int'(e.thres));
            if (kind == 2) begin
                check_output("err_busy", int'(busy), 0);
            end else begin
                check_output("reg_clear_cycles", a_clr, e.clr);
                check_output("cscan_cycles", a_scan, e.scan);
                check_output("cell_sc_pulses", a_sc, e.sc);
                check_output("pipe_en_cycles", a_pe, e.pe);
                check_output("pipe_en_drain", a_ped, e.ped);
                check_output("c_switch_cycles", a_csw, e.csw);
                check_output("busy_latency", a_lat, e.lat);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            clear_acc();
            prev_busy = 0;
            got_done  = 0;
        end else begin
            if (err) pop_check(2);
            if (busy && !done) begin
                a_lat++;
                a_clr  += int'(reg_clear);
                a_scan += int'(cscan_en);
                a_sc   += int'(cell_sc_en);
                a_csw  += int'(c_switch);
                if (c_switch) a_ped += int'(pipeline_en);
                else          a_pe  += int'(pipeline_en);
                if (c_switch != out_valid) check_output("out_valid_eq_c_switch", int'(out_valid), int'(c_switch));
            end
            if (done) begin
                pop_check(0);
                got_done = 1;
            end
            if (prev_busy && !busy) begin
                if (!got_done) pop_check(1);
                clear_acc();
                got_done = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic apply_stimulus(input logic [K_W-1:0] k, input logic [WT-1:0] th);
        @(posedge clk);
        #1;
        start = 1'b1; cfg_k = k; cfg_thres = th;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) check_output("job_timeout", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", int'(busy), 0);
        check_output("reset_reg_clear", int'(reg_clear), 0);
        check_output("reset_in_ready", int'(in_ready), 0);
        check_output("reset_thres", int'(Thres), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal job with a start while busy and a cfg_thres change mid-job.
        push_exp(0, 1, 4, 1, 9, 4, 4, 18, 2'b10);
        apply_stimulus(16'd3, 2'b10);
        repeat (6) @(posedge clk);
        #1;
        start = 1'b1; cfg_k = 16'd5; cfg_thres = 2'b01;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_idle(100);

        // Feeder and sink stalls.
        stall_mode = 1;
        push_exp(0, 1, 4, 1, 9, 4, 7, 23, 2'b11);
        apply_stimulus(16'd3, 2'b11);
        wait_idle(100);
        stall_mode = 0;

        // Rejected start keeps previously latched threshold.
        push_exp(2, 0, 0, 0, 0, 0, 0, 0, 2'b11);
        apply_stimulus(16'd0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        check_output("reject_busy", int'(busy), 0);

        // Abort in the second FLUSH cycle, then an immediate new job.
        push_exp(1, 2, 4, 1, 4, 0, 0, 10, 2'b01);
        apply_stimulus(16'd2, 2'b01);
        repeat (8) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(posedge clk);
        push_exp(0, 1, 4, 1, 7, 4, 4, 16, 2'b00);
        apply_stimulus(16'd1, 2'b00);
        wait_idle(100);

        // Reset asserted mid-COMPUTE.
        apply_stimulus(16'd10, 2'b01);
        begin
            int n = 0;
            while (!(in_ready && !cscan_en) && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_output("reach_compute", int'(in_ready && !cscan_en), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_outputs", int'({in_ready, out_valid, pipeline_en, reg_clear,
                     cell_sc_en, cscan_en, c_switch, done, err}), 0);
        check_output("rst_thres", int'(Thres), 0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("post_rst_busy", int'(busy), 0);

        // Recovery job after reset.
        push_exp(0, 1, 4, 1, 7, 4, 4, 16, 2'b10);
        apply_stimulus(16'd1, 2'b10);
        wait_idle(100);

        check_output("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
